// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM state type and helpers for the MEM-stage data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    function automatic int tag_width(input int line_words, input int sets);
        return 30 - $clog2(line_words) - $clog2(sets);
    endfunction

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] bmask;
        bmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        return (old_word & ~bmask) | (new_word & bmask);
    endfunction

endpackage

// File: rtl/dcache_mem_fsm.sv
// rtl/dcache_mem_fsm.sv - miss handler: word-serial victim writeback then line refill over req/ack
module dcache_mem_fsm
    import dcache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = 2,
    parameter int IDX_W      = 4,
    parameter int TAG_W      = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss,
    input  logic                        victim_dirty,
    input  logic [TAG_W-1:0]            req_tag,
    input  logic [TAG_W-1:0]            victim_tag,
    input  logic [IDX_W-1:0]            idx,
    input  logic [LINE_WORDS-1:0][31:0] victim_line,
    input  logic                        mem_ack,
    output state_t                      state,
    output logic [OFF_W-1:0]            cnt,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata
);

    logic [OFF_W-1:0] cnt_nxt;
    logic             last;

    assign cnt_nxt = cnt + 1'b1;
    assign last    = (cnt == OFF_W'(LINE_WORDS - 1));

    // mem_* are loaded with the values for the word about to be transferred,
    // so they stay stable for as long as the responder withholds mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (victim_dirty) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {victim_tag, idx, {OFF_W{1'b0}}, 2'b00};
                            mem_wdata <= victim_line[0];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, idx, {OFF_W{1'b0}}, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (last) begin
                            cnt      <= '0;
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, idx, {OFF_W{1'b0}}, 2'b00};
                        end else begin
                            cnt       <= cnt_nxt;
                            mem_addr  <= {victim_tag, idx, cnt_nxt, 2'b00};
                            mem_wdata <= victim_line[cnt_nxt];
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (last) begin
                            cnt     <= '0;
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_addr <= {req_tag, idx, cnt_nxt, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// rtl/mem_stage_dcache.sv - direct-mapped write-back D-cache for the MEM stage; DCACHE_STATS_EN adds hit/miss counters
module mem_stage_dcache #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    input  logic        req_rd,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    import dcache_pkg::*;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_width(LINE_WORDS, SETS);

    logic [SETS-1:0]             valid;
    logic [SETS-1:0]             dirty;
    logic [TAG_W-1:0]            tag_arr  [SETS];
    logic [LINE_WORDS-1:0][31:0] data_arr [SETS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             store;
    logic             active;
    logic             hit;
    logic             store_commit;
    logic             fill_wr;
    logic             fill_last;
    state_t           state;
    logic [OFF_W-1:0] cnt;
    logic             unused_addr_bits;

    assign off              = req_addr[OFF_W+1:2];
    assign idx              = req_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag              = req_addr[31:OFF_W+IDX_W+2];
    assign unused_addr_bits = ^req_addr[1:0];

    assign store        = |req_we;
    assign active       = req_rd | store;
    assign hit          = active & valid[idx] & (tag_arr[idx] == tag);
    assign stall        = (active & ~hit) | (state != IDLE);
    assign rd_data      = hit ? data_arr[idx][off] : 32'd0;
    assign store_commit = store & hit & ~stall;
    assign fill_wr      = (state == FILL) & mem_ack;
    assign fill_last    = fill_wr & (cnt == OFF_W'(LINE_WORDS - 1));

    dcache_mem_fsm #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .miss         (active & ~hit),
        .victim_dirty (valid[idx] & dirty[idx]),
        .req_tag      (tag),
        .victim_tag   (tag_arr[idx]),
        .idx          (idx),
        .victim_line  (data_arr[idx]),
        .mem_ack      (mem_ack),
        .state        (state),
        .cnt          (cnt),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_last) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (store_commit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag and data storage is deliberately not reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_wr) begin
                data_arr[idx][cnt] <= mem_rdata;
                if (fill_last) begin
                    tag_arr[idx] <= tag;
                end
            end else if (store_commit) begin
                data_arr[idx][off] <= merge_bytes(data_arr[idx][off], req_wdata, req_we);
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else if (active) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb/tb_mem_stage_dcache.sv - randomized self-checking bench for mem_stage_dcache against a flat-memory model
`timescale 1ns/1ps
module tb_mem_stage_dcache;

    localparam int LW     = 4;
    localparam int NSETS  = 16;
    localparam int OFF_W  = 2;
    localparam int IDX_W  = 4;
    localparam int TAG_SH = OFF_W + IDX_W + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;
    logic        req_rd;
    logic [31:0] rd_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [31:0] backing [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_valid [NSETS];
    bit          m_dirty [NSETS];
    logic [31:0] m_tag   [NSETS];

    always #5 clk = ~clk;

    mem_stage_dcache #(.LINE_WORDS(LW), .SETS(NSETS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_rd    (req_rd),
        .rd_data   (rd_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5EED_1234;
    endfunction

    function automatic logic [31:0] rd_backing(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return mem_init(a);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Architectural state after a reset is whatever main memory holds.
    task automatic model_reset();
        for (int i = 0; i < NSETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        ref_mem.delete();
        foreach (backing[k]) ref_mem[k] = backing[k];
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One MEM-stage request held until it completes; the task plays main memory.
    task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                          input logic rd, input int delay, input int abort_after,
                          output bit aborted, output logic [31:0] got_rd);
        logic [31:0] wa, tagv, base_v, base_n, rec_addr, rec_wd, exp_rd;
        logic        rec_we;
        int          idx, n, waitc, guard, cur_delay;
        bit          hit_exp;
        logic [31:0] q_addr [$];
        logic        q_we   [$];
        logic [31:0] q_wd   [$];
        aborted = 1'b0;
        wa      = {addr[31:2], 2'b00};
        idx     = int'((wa >> (OFF_W + 2)) & (NSETS - 1));
        tagv    = wa >> TAG_SH;
        hit_exp = m_valid[idx] && (m_tag[idx] == tagv);
        @(negedge clk);
        req_addr = addr; req_we = we; req_wdata = wdata; req_rd = rd; mem_ack = 1'b0;
        #1;
        checks++;
        if (stall !== !hit_exp) begin
            errors++;
            $display("FAIL stall_on_issue addr=%h got=%b want=%b", addr, stall, !hit_exp);
        end
        if (!hit_exp) begin
            exp_misses++;
            base_n = (tagv << TAG_SH) | (32'(idx) << (OFF_W + 2));
            if (m_valid[idx] && m_dirty[idx]) begin
                base_v = (m_tag[idx] << TAG_SH) | (32'(idx) << (OFF_W + 2));
                for (int w = 0; w < LW; w++) begin
                    q_addr.push_back(base_v + 32'(4 * w)); q_we.push_back(1'b1);
                    q_wd.push_back(rd_ref(base_v + 32'(4 * w)));
                end
            end
            for (int w = 0; w < LW; w++) begin
                q_addr.push_back(base_n + 32'(4 * w)); q_we.push_back(1'b0); q_wd.push_back(32'd0);
            end
            n = 0; waitc = 0; guard = 0;
            cur_delay = (delay < 0) ? int'($urandom_range(0, 2)) : delay;
            while (q_addr.size() > 0 && guard < 500 && !(abort_after >= 0 && n == abort_after)) begin
                @(negedge clk);
                mem_ack = 1'b0;
                guard++;
                if (mem_req === 1'b1) begin
                    if (waitc == 0) begin
                        rec_addr = mem_addr; rec_we = mem_we; rec_wd = mem_wdata;
                    end else begin
                        checks++;
                        if (mem_addr !== rec_addr || mem_we !== rec_we || (rec_we && mem_wdata !== rec_wd)) begin
                            errors++;
                            $display("FAIL mem_stable got=%h/%b/%h want=%h/%b/%h",
                                     mem_addr, mem_we, mem_wdata, rec_addr, rec_we, rec_wd);
                        end
                    end
                    if (waitc >= cur_delay) begin
                        checks++;
                        if (mem_addr !== q_addr[0] || mem_we !== q_we[0] || (q_we[0] && mem_wdata !== q_wd[0])) begin
                            errors++;
                            $display("FAIL mem_xfer got=%h/%b/%h want=%h/%b/%h",
                                     mem_addr, mem_we, mem_wdata, q_addr[0], q_we[0], q_wd[0]);
                        end
                        if (q_we[0]) backing[q_addr[0]] = mem_wdata;
                        else mem_rdata = rd_backing(q_addr[0]);
                        mem_ack = 1'b1;
                        void'(q_addr.pop_front()); void'(q_we.pop_front()); void'(q_wd.pop_front());
                        n++; waitc = 0;
                        cur_delay = (delay < 0) ? int'($urandom_range(0, 2)) : delay;
                    end else begin
                        waitc++;
                    end
                end
            end
            if (abort_after >= 0 && n == abort_after) begin
                aborted = 1'b1;
                got_rd  = 32'd0;
                return;
            end
            if (guard >= 500) begin
                checks++; errors++;
                $display("FAIL mem_timeout got=%0d transfers want=%0d", n, n + q_addr.size());
                got_rd = 32'd0;
                return;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            checks++;
            if (mem_req !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL refill_done got=req%b/stall%b want=req0/stall0", mem_req, stall);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tagv;
            m_dirty[idx] = 1'b0;
        end
        exp_rd = rd_ref(wa);
        got_rd = rd_data;
        checks++;
        if (rd_data !== exp_rd) begin
            errors++;
            $display("FAIL rd_data addr=%h got=%h want=%h", addr, rd_data, exp_rd);
        end
        exp_hits++;
        if (we != 4'h0) begin
            ref_mem[wa]  = merge_model(exp_rd, wdata, we);
            m_dirty[idx] = 1'b1;
        end
        @(negedge clk);
        req_rd = 1'b0; req_we = 4'h0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_stall got=%b want=0", stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_rd = 1'b0; req_we = 4'h0; req_addr = 32'h40; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem got=%b/%b/%h/%h want=0/0/0/0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (stall !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got=stall%b/rd%h want=stall0/rd0", stall, rd_data);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got=%0d/%0d want=0/0", hit_cnt, miss_cnt);
        end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_plan_sequence();
        bit          ab;
        logic [31:0] rv;
        access(32'h0000_0040, 4'h0, 32'h0, 1'b1, -1, -1, ab, rv);
        access(32'h0000_0044, 4'hF, 32'h1111_2222, 1'b0, -1, -1, ab, rv);
        access(32'h0000_0044, 4'b0011, 32'hAABB_CCDD, 1'b0, -1, -1, ab, rv);
        access(32'h0000_0044, 4'h0, 32'h0, 1'b1, -1, -1, ab, rv);
        checks++;
        if (rv !== 32'h1111_CCDD) begin
            errors++;
            $display("FAIL store_merge got=%h want=%h", rv, 32'h1111_CCDD);
        end
        access(32'h0000_0440, 4'h0, 32'h0, 1'b1, -1, -1, ab, rv);
        checks++;
        if (rd_backing(32'h44) !== 32'h1111_CCDD) begin
            errors++;
            $display("FAIL writeback_word1 got=%h want=%h", rd_backing(32'h44), 32'h1111_CCDD);
        end
    endtask

    task automatic test_slow_ack();
        bit          ab;
        logic [31:0] rv;
        access(32'h0000_0448, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, -1, ab, rv);
        access(32'h0000_0840, 4'h0, 32'h0, 1'b1, 3, -1, ab, rv);
        access(32'h0000_044B, 4'h0, 32'h0, 1'b1, 3, -1, ab, rv);
    endtask

    task automatic test_random(input int count);
        for (int i = 0; i < count; i++) begin
            logic [31:0] a;
            logic [31:0] rv;
            logic [3:0]  m;
            int          mode;
            bit          ab;
            a = (32'($urandom_range(0, 3)) << TAG_SH) | (32'($urandom_range(0, NSETS - 2)) << (OFF_W + 2))
              | (32'($urandom_range(0, LW - 1)) << 2) | 32'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            m = (mode == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            access(a, m, $urandom, mode != 1, -1, -1, ab, rv);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        checks++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stats got=%0d/%0d want=%0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
    endtask
`endif

    task automatic test_reset_mid_fill();
        bit          ab;
        logic [31:0] rv;
        access(32'h0000_05F0, 4'h0, 32'h0, 1'b1, -1, 2, ab, rv);
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL abort_reached got=%b want=1", ab);
        end
        @(negedge clk);
        mem_ack = 1'b0; rst = 1'b1; req_rd = 1'b0; req_we = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_fill got=%b/%b/%h want=0/0/0", mem_req, mem_we, mem_addr);
        end
        rst = 1'b0;
        model_reset();
        access(32'h0000_05F0, 4'h0, 32'h0, 1'b1, -1, -1, ab, rv);
        test_random(20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_plan_sequence();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_slow_ack();
        test_random(80);
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_fill();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
